// File: rtl/pc_sequencer.sv
// pc_sequencer -- next-PC controller for the single-cycle MIPS core.
//
// The PC register downstream has no enable. This block therefore drives its
// load value on every cycle, and it holds the PC by returning pc_cur. It
// chooses between the sequential, branch, jump, jump-register and
// exception-vector targets. It also sequences boot, instruction-memory stalls,
// halt/resume and exception entry, and records EPC and the exception cause.
//
// Ports
//   clk           in   1   clock, rising edge
//   rst_n         in   1   asynchronous active-low reset
//   pc_cur        in  32   current PC (PC register output)
//   imem_ready    in   1   instruction memory data valid for pc_cur
//   branch_taken  in   1   conditional branch resolved taken
//   branch_offset in  32   sign-extended word offset
//   jump          in   1   J/JAL
//   jump_index    in  26   instr[25:0]
//   jump_reg      in   1   JR/JALR
//   rs_value      in  32   register rs contents
//   exc_req       in   1   external/decoder exception request
//   halt_req      in   1   enter HALT
//   resume        in   1   leave HALT
//   pc_next       out 32   PC load value (combinational)
//   fetch_valid   out  1   current instruction may retire
//   state         out  2   00 BOOT, 01 RUN, 10 WAIT, 11 HALT
//   epc           out 32   PC of the faulting instruction
//   exc_cause     out  2   00 none, 01 external, 10 misaligned JR, 11 fetch timeout
//
// state | meaning
// BOOT  | one cycle after reset, loads RESET_VECTOR
// RUN   | normal fetch/retire, resolves next PC
// WAIT  | instruction memory not ready, PC held, stall counted
// HALT  | PC held until resume or exception

module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int unsigned STALL_LIMIT  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_cur,
    input  logic        imem_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] rs_value,
    input  logic        exc_req,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] pc_next,
    output logic        fetch_valid,
    output logic [1:0]  state,
    output logic [31:0] epc,
    output logic [1:0]  exc_cause
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_WAIT = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    localparam logic [1:0] CAUSE_EXT     = 2'b01;
    localparam logic [1:0] CAUSE_JR_MIS  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;
    localparam logic [7:0] STALL_LIM     = 8'(STALL_LIMIT);

    state_t      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [31:0] pc_next_c;
    logic        fetch_valid_c;

    logic [31:0] pc4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic        jr_misaligned;

    // All target arithmetic wraps modulo 2^32.
    assign pc4           = pc_cur + 32'd4;
    assign br_tgt        = pc4 + (branch_offset << 2);
    assign j_tgt         = {pc4[31:28], jump_index, 2'b00};
    assign jr_misaligned = jump_reg && (rs_value[1:0] != 2'b00);

    always_comb begin
        state_d       = state_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        cnt_d         = cnt_q;
        pc_next_c     = pc_cur;
        fetch_valid_c = 1'b0;

        case (state_q)
            ST_BOOT: begin
                pc_next_c = RESET_VECTOR;
                state_d   = ST_RUN;
            end

            ST_RUN: begin
                if (exc_req) begin
                    pc_next_c = EXC_VECTOR;
                    epc_d     = pc_cur;
                    cause_d   = CAUSE_EXT;
                end else if (jr_misaligned) begin
                    pc_next_c = EXC_VECTOR;
                    epc_d     = pc_cur;
                    cause_d   = CAUSE_JR_MIS;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else if (!imem_ready) begin
                    // The cycle spent here counts as the first stall cycle.
                    cnt_d   = 8'd1;
                    state_d = ST_WAIT;
                end else begin
                    fetch_valid_c = 1'b1;
                    if (jump_reg) begin
                        pc_next_c = rs_value;
                    end else if (jump) begin
                        pc_next_c = j_tgt;
                    end else if (branch_taken) begin
                        pc_next_c = br_tgt;
                    end else begin
                        pc_next_c = pc4;
                    end
                end
            end

            ST_WAIT: begin
                if (exc_req) begin
                    pc_next_c = EXC_VECTOR;
                    epc_d     = pc_cur;
                    cause_d   = CAUSE_EXT;
                    cnt_d     = 8'd0;
                    state_d   = ST_RUN;
                end else if (imem_ready) begin
                    // The instruction retires on the following RUN cycle.
                    cnt_d   = 8'd0;
                    state_d = ST_RUN;
                end else if (cnt_q == STALL_LIM) begin
                    pc_next_c = EXC_VECTOR;
                    epc_d     = pc_cur;
                    cause_d   = CAUSE_TIMEOUT;
                    cnt_d     = 8'd0;
                    state_d   = ST_RUN;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_HALT: begin
                if (exc_req) begin
                    pc_next_c = EXC_VECTOR;
                    epc_d     = pc_cur;
                    cause_d   = CAUSE_EXT;
                    state_d   = ST_RUN;
                end else if (resume) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            epc_q   <= 32'h0000_0000;
            cause_q <= 2'b00;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    // The explicit reset gating keeps the PC load value defined while reset
    // is asserted, independent of the state register.
    assign pc_next     = rst_n ? pc_next_c : RESET_VECTOR;
    assign fetch_valid = rst_n & fetch_valid_c;
    assign state       = state_q;
    assign epc         = epc_q;
    assign exc_cause   = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam logic [31:0] EXC = 32'h8000_0180;
    localparam logic [1:0] S_BOOT = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_WAIT = 2'b10;
    localparam logic [1:0] S_HALT = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_cur;
    logic        imem_ready;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] rs_value;
    logic        exc_req;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc_next;
    logic        fetch_valid;
    logic [1:0]  state;
    logic [31:0] epc;
    logic [1:0]  exc_cause;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .imem_ready(imem_ready),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index), .jump_reg(jump_reg),
        .rs_value(rs_value), .exc_req(exc_req), .halt_req(halt_req),
        .resume(resume), .pc_next(pc_next), .fetch_valid(fetch_valid),
        .state(state), .epc(epc), .exc_cause(exc_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        fv;
        logic [1:0]  st;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        br;
        logic [31:0] off;
        logic        j;
        logic [25:0] idx;
        logic        jr;
        logic [31:0] rs;
        logic [31:0] exp_pc;
    } vec_t;

    exp_t exp_q[$];
    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;
    bit   closed = 1'b1;   // when set, pc_cur follows pc_next like the real PC register

    task automatic cmp32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_now(input string name, input logic [31:0] pc, input logic fv, input logic [1:0] st);
        exp_t e;
        e.name = name; e.pc = pc; e.fv = fv; e.st = st;
        exp_q.push_back(e);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            cmp32({e.name, ".pc_next"}, pc_next, e.pc);
            cmp32({e.name, ".fetch_valid"}, {31'b0, fetch_valid}, {31'b0, e.fv});
            cmp32({e.name, ".state"}, {30'b0, state}, {30'b0, e.st});
        end
    endtask

    task automatic cyc(input string name, input logic [31:0] pc, input logic fv, input logic [1:0] st);
        logic [31:0] nxt;
        check_now(name, pc, fv, st);
        nxt = pc_next;
        @(posedge clk);
        @(negedge clk);
        if (closed) pc_cur = nxt;
    endtask

    task automatic chk_exc(input string name, input logic [31:0] e_epc, input logic [1:0] e_cause);
        cmp32({name, ".epc"}, epc, e_epc);
        cmp32({name, ".exc_cause"}, {30'b0, exc_cause}, {30'b0, e_cause});
    endtask

    task automatic idle();
        imem_ready = 1'b1; branch_taken = 1'b0; branch_offset = '0;
        jump = 1'b0; jump_index = '0; jump_reg = 1'b0; rs_value = '0;
        exc_req = 1'b0; halt_req = 1'b0; resume = 1'b0;
    endtask

    task automatic add_vec(input string name, input logic [31:0] pc, input logic br,
                           input logic [31:0] off, input logic j, input logic [25:0] idx,
                           input logic jr, input logic [31:0] rs, input logic [31:0] exp_pc);
        vec_t v;
        v.name = name; v.pc = pc; v.br = br; v.off = off; v.j = j; v.idx = idx;
        v.jr = jr; v.rs = rs; v.exp_pc = exp_pc;
        vq.push_back(v);
    endtask

    initial begin
        add_vec("seq",        32'h0000_0100, 0, 32'h0,         0, 26'h0,       0, 32'h0,      32'h0000_0104);
        add_vec("branch_neg", 32'h0000_0100, 1, 32'hFFFF_FFFE, 0, 26'h0,       0, 32'h0,      32'h0000_00FC);
        add_vec("jump_wins",  32'h0000_0100, 1, 32'hFFFF_FFFE, 1, 26'h40,      0, 32'h0,      32'h0000_0100);
        add_vec("seq_wrap",   32'hFFFF_FFFC, 0, 32'h0,         0, 26'h0,       0, 32'h0,      32'h0000_0000);
        add_vec("jr",         32'h0000_0200, 0, 32'h0,         0, 26'h0,       1, 32'h3000,   32'h0000_3000);
        add_vec("jr_over_j",  32'h0000_1000, 1, 32'h10,        1, 26'h55,      1, 32'h4000,   32'h0000_4000);
        add_vec("jump_top",   32'hF000_0000, 0, 32'h0,         1, 26'h3FFFFFF, 0, 32'h0,      32'hFFFF_FFFC);
        add_vec("branch_pos", 32'h7FFF_FFFC, 1, 32'h1,         0, 26'h0,       0, 32'h0,      32'h8000_0004);
        add_vec("jump_region",32'h0FFF_FFFC, 0, 32'h0,         1, 26'h1,       0, 32'h0,      32'h1000_0004);

        // Reset and boot
        idle();
        rst_n = 1'b0;
        pc_cur = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check_now("in_reset", 32'h0, 1'b0, S_BOOT);
        chk_exc("in_reset", 32'h0, 2'b00);
        rst_n = 1'b1;
        cyc("boot", 32'h0, 1'b0, S_BOOT);
        cyc("run_0", 32'h4, 1'b1, S_RUN);
        cyc("run_4", 32'h8, 1'b1, S_RUN);
        cyc("run_8", 32'hC, 1'b1, S_RUN);

        // Target selection table
        closed = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            idle();
            pc_cur = vq[i].pc; branch_taken = vq[i].br; branch_offset = vq[i].off;
            jump = vq[i].j; jump_index = vq[i].idx; jump_reg = vq[i].jr; rs_value = vq[i].rs;
            cyc(vq[i].name, vq[i].exp_pc, 1'b1, S_RUN);
        end
        chk_exc("no_exc_yet", 32'h0, 2'b00);

        // Misaligned JR
        idle();
        pc_cur = 32'hFFFF_FFFC; jump_reg = 1'b1; rs_value = 32'h0000_2002;
        cyc("jr_mis", EXC, 1'b0, S_RUN);
        chk_exc("jr_mis", 32'hFFFF_FFFC, 2'b10);

        // External exception beats halt
        idle();
        pc_cur = 32'h500; exc_req = 1'b1; halt_req = 1'b1;
        cyc("exc_run", EXC, 1'b0, S_RUN);
        chk_exc("exc_run", 32'h500, 2'b01);
        idle();
        pc_cur = 32'h600;
        cyc("after_exc", 32'h604, 1'b1, S_RUN);

        // Short stall
        closed = 1'b1;
        idle();
        pc_cur = 32'h40; imem_ready = 1'b0;
        cyc("stall_enter", 32'h40, 1'b0, S_RUN);
        cyc("stall_w1", 32'h40, 1'b0, S_WAIT);
        cyc("stall_w2", 32'h40, 1'b0, S_WAIT);
        imem_ready = 1'b1;
        cyc("stall_rdy", 32'h40, 1'b0, S_WAIT);
        cyc("stall_ret", 32'h44, 1'b1, S_RUN);
        chk_exc("stall_sticky", 32'h500, 2'b01);

        // Exception taken in WAIT
        pc_cur = 32'h60; imem_ready = 1'b0;
        cyc("wexc_enter", 32'h60, 1'b0, S_RUN);
        cyc("wexc_w1", 32'h60, 1'b0, S_WAIT);
        exc_req = 1'b1;
        cyc("wexc_take", EXC, 1'b0, S_WAIT);
        idle();
        chk_exc("wexc", 32'h60, 2'b01);
        cyc("wexc_run", EXC + 32'd4, 1'b1, S_RUN);

        // Fetch timeout
        pc_cur = 32'h80; imem_ready = 1'b0;
        cyc("to_enter", 32'h80, 1'b0, S_RUN);
        for (int i = 1; i < 8; i++) cyc("to_wait", 32'h80, 1'b0, S_WAIT);
        cyc("to_fire", EXC, 1'b0, S_WAIT);
        chk_exc("timeout", 32'h80, 2'b11);
        imem_ready = 1'b1;
        cyc("to_vec", EXC + 32'd4, 1'b1, S_RUN);

        // Halt / resume
        pc_cur = 32'h20; halt_req = 1'b1;
        cyc("halt_req", 32'h20, 1'b0, S_RUN);
        cyc("halt_again", 32'h20, 1'b0, S_HALT);
        halt_req = 1'b0;
        for (int i = 0; i < 3; i++) cyc("halt_hold", 32'h20, 1'b0, S_HALT);
        resume = 1'b1;
        cyc("resume", 32'h20, 1'b0, S_HALT);
        resume = 1'b0;
        cyc("resumed", 32'h24, 1'b1, S_RUN);

        // Exception in HALT beats resume
        halt_req = 1'b1;
        cyc("h2_req", 32'h24, 1'b0, S_RUN);
        halt_req = 1'b0; exc_req = 1'b1; resume = 1'b1;
        cyc("h2_exc", EXC, 1'b0, S_HALT);
        idle();
        chk_exc("h2_exc", 32'h24, 2'b01);
        cyc("h2_run", EXC + 32'd4, 1'b1, S_RUN);

        // Reset during HALT
        halt_req = 1'b1;
        cyc("h3_req", EXC + 32'd4, 1'b0, S_RUN);
        halt_req = 1'b0;
        cyc("h3_hold", EXC + 32'd4, 1'b0, S_HALT);
        #2;
        rst_n = 1'b0;
        check_now("rst_in_halt", 32'h0, 1'b0, S_BOOT);
        chk_exc("rst_in_halt", 32'h0, 2'b00);
        @(negedge clk);
        pc_cur = 32'h0;
        rst_n = 1'b1;
        cyc("reboot", 32'h0, 1'b0, S_BOOT);
        cyc("reboot_run", 32'h4, 1'b1, S_RUN);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the single-cycle MIPS core. It drives the PC register's load input every cycle; that register has no enable, so holding is done by driving back the current PC.
- Selects among sequential, branch, jump, jump-register and exception-vector targets.
- Sequences boot, instruction-memory stall, halt/resume and exception entry. Records EPC and the exception cause.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- EXC_VECTOR, 32'h8000_0180, exception handler address.
- STALL_LIMIT, 8, consecutive not-ready cycles in WAIT before a fetch-timeout exception (range 1..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pc_cur  in  32  current PC (PC register output).
- imem_ready  in  1  instruction memory has valid data for pc_cur.
- branch_taken  in  1  conditional branch resolved taken.
- branch_offset  in  32  sign-extended 16-bit immediate (word offset).
- jump  in  1  J/JAL.
- jump_index  in  26  instr[25:0].
- jump_reg  in  1  JR/JALR.
- rs_value  in  32  register rs contents.
- exc_req  in  1  external/decoder exception request.
- halt_req  in  1  enter HALT.
- resume  in  1  leave HALT.
- pc_next  out  32  value loaded into the PC at the next edge (combinational).
- fetch_valid  out  1  current instruction may retire (register writes enabled).
- state  out  2  00 BOOT, 01 RUN, 10 WAIT, 11 HALT.
- epc  out  32  PC of the faulting instruction (registered).
- exc_cause  out  2  00 none, 01 external, 10 misaligned JR, 11 fetch timeout (registered, sticky until next exception).

Behaviour:
- Reset (async): state=BOOT, epc=0, exc_cause=00, stall count=0.
- Combinational outputs while rst_n low: pc_next=RESET_VECTOR, fetch_valid=0.
- Arithmetic, all mod 2^32 with wrap-around and no overflow flag:
  - pc4 = pc_cur+4
  - br_tgt = pc4 + (branch_offset<<2)
  - j_tgt = {pc4[31:28], jump_index, 2'b00}
- BOOT: pc_next=RESET_VECTOR, fetch_valid=0; next state RUN unconditionally (1 cycle).
- RUN, first match wins:
  1. exc_req: pc_next=EXC_VECTOR, epc<=pc_cur, cause<=01, fetch_valid=0, stay RUN.
  2. jump_reg with rs_value[1:0]!=0: same as 1 but cause<=10.
  3. halt_req: pc_next=pc_cur, fetch_valid=0, next state HALT.
  4. !imem_ready: pc_next=pc_cur, fetch_valid=0, stall count<=1, next state WAIT.
  5. jump_reg: pc_next=rs_value.
  6. jump: pc_next=j_tgt.
  7. branch_taken: pc_next=br_tgt.
  8. otherwise: pc_next=pc4.
  - Cases 5–8 set fetch_valid=1.
  - branch_taken together with jump: jump wins.
- WAIT: pc_next=pc_cur, fetch_valid=0.
  - exc_req: take exception as in RUN case 1, then go to RUN; count clears.
  - imem_ready: return to RUN; count clears; the instruction completes next cycle in RUN. No fetch_valid in WAIT, so there is one cycle of extra latency after ready.
  - Otherwise, if count==STALL_LIMIT: pc_next=EXC_VECTOR, epc<=pc_cur, cause<=11, go to RUN, count clears.
  - Otherwise count<=count+1. The counter saturates and never wraps.
- HALT: pc_next=pc_cur, fetch_valid=0.
  - exc_req is taken (cause 01, go to RUN).
  - Else resume goes to RUN, and the held instruction retires on the next RUN cycle.
  - halt_req while in HALT is ignored.
- epc/exc_cause change only on exception entry.
- Reset asserted mid-stall or mid-halt aborts immediately to BOOT.

Test Plan:
- Reset release, imem_ready=1, no controls: state BOOT→RUN; PC sequence 0x0, 0x4, 0x8, 0xC; fetch_valid=0 in BOOT, 1 from RUN.
- pc_cur=0x0000_0100, branch_taken=1, branch_offset=0xFFFF_FFFE -> pc_next=0x0000_00FC. Same cycle with jump=1, jump_index=0x000_0040 -> pc_next=0x0000_0100 (jump wins).
- pc_cur=0xFFFF_FFFC, no control -> pc_next=0x0000_0000 (wrap). jump_reg=1, rs_value=0x0000_2002 -> pc_next=0x8000_0180, epc=0xFFFF_FFFC, exc_cause=10.
- imem_ready low 3 cycles at pc_cur=0x40 -> state WAIT, pc held at 0x40, fetch_valid=0. Then ready -> RUN, next pc 0x44.
- imem_ready held low with STALL_LIMIT=8 at pc_cur=0x80 -> after 8 WAIT cycles pc_next=0x8000_0180, exc_cause=11, epc=0x80.
- halt_req at pc 0x20, resume 5 cycles later -> PC held at 0x20 throughout. Then 0x24. rst_n pulsed low during HALT -> state=BOOT immediately, pc_next=RESET_VECTOR.
